// File: rtl/axil_cfg_master_pkg.sv
// axil_cfg_master_pkg
//   Shared types and constants for the AXI4-Lite configuration initiator:
//   the controller state encoding and the AXI response codes.
package axil_cfg_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cfg_watchdog.sv
// axil_cfg_watchdog
//   Cycle counter that flags expiry after TIMEOUT_CYCLES consecutive active
//   cycles without a restart.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   active      count enable (controller is waiting on the slave)
//   restart     clear the count (controller is changing state)
//   expired     high on the TIMEOUT_CYCLES-th active cycle
module axil_cfg_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic restart,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || !active) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // The count starts at 0 on the first waiting cycle, so TIMEOUT_CYCLES-1
    // marks the last cycle the controller is allowed to wait.
    assign expired = active && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/axil_cfg_master.sv
// axil_cfg_master
//   AXI4-Lite initiator converting a one-command-at-a-time request/response
//   port into AXI4-Lite read and write transactions. AW and W are issued
//   together and retire independently; one transaction is outstanding.
// Optional feature macro: AXIL_CFG_MASTER_TIMEOUT_EN enables a watchdog that
//   abandons a stalled transaction after TIMEOUT_CYCLES and reports it with
//   rsp_timeout = 1 and rsp_resp = SLVERR.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata command request port
//   rsp_valid/ready/rdata/resp/timeout response port
//   aw*, w*, b*, ar*, r*            AXI4-Lite master channels (no strobes/prot)
// All outputs decode from flops only; there is no input-to-output path.
module axil_cfg_master
    import axil_cfg_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 13,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                state, state_next;
    logic                  aw_done, w_done;
    logic                  aw_fire, w_fire;
    logic                  expired;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            resp_q;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

`ifdef AXIL_CFG_MASTER_TIMEOUT_EN
    logic wd_active;
    logic timeout_q;

    assign wd_active = (state == WR) || (state == WR_RESP) ||
                       (state == RD_ADDR) || (state == RD_DATA);

    axil_cfg_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .active (wd_active),
        .restart(state_next != state),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (state != RSP && state_next == RSP) begin
            // Any entry into RSP without a B or R handshake is a watchdog expiry.
            timeout_q <= !((state == WR_RESP && bvalid) || (state == RD_DATA && rvalid));
        end
    end

    assign rsp_timeout = timeout_q;
`else
    assign expired     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a real handshake takes precedence over expiry
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = cmd_write ? WR : RD_ADDR;
            WR: begin
                if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
                else if (expired)                               state_next = RSP;
            end
            WR_RESP: if (bvalid || expired) state_next = RSP;
            RD_ADDR: begin
                if (arready)      state_next = RD_DATA;
                else if (expired) state_next = RSP;
            end
            RD_DATA: if (rvalid || expired) state_next = RSP;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from registered state and retire flags
    always_comb begin
        cmd_ready = (state == IDLE);
        awvalid   = (state == WR) && !aw_done;
        wvalid    = (state == WR) && !w_done;
        bready    = (state == WR_RESP);
        arvalid   = (state == RD_ADDR);
        rready    = (state == RD_DATA);
        rsp_valid = (state == RSP);
    end

    // Command latch, per-channel retire flags and response payload
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
            end

            // Retire flags live only while the write stays in WR.
            if (state == WR && state_next == WR) begin
                if (aw_fire) aw_done <= 1'b1;
                if (w_fire)  w_done  <= 1'b1;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end

            if (state != RSP && state_next == RSP) begin
                if (state == WR_RESP && bvalid) begin
                    rdata_q <= '0;
                    resp_q  <= bresp;
                end else if (state == RD_DATA && rvalid) begin
                    rdata_q <= rdata;
                    resp_q  <= rresp;
                end else begin
                    rdata_q <= '0;
                    resp_q  <= RESP_SLVERR;
                end
            end
        end
    end

    assign awaddr    = addr_q;
    assign araddr    = addr_q;
    assign wdata     = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;

endmodule

// File: doc/axil_cfg_master.md
Name: axil_cfg_master

Overview:
- AXI4-Lite initiator that turns a simple one-command-at-a-time request/response port into AXI4-Lite read and write transactions.
- Drives the Garnet axi4_slave_* config port from RTL-side controllers, such as a host bridge or a bring-up sequencer, in place of the testbench driver.
- One transaction outstanding at a time; AW and W are issued together, each retiring independently.

Parameters:
- ADDR_WIDTH, 13, AXI address width; matches CGRA_AXI_ADDR_WIDTH.
- DATA_WIDTH, 32, AXI data width; matches CGRA_AXI_DATA_WIDTH.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP/RRESP returned by the slave
- rsp_timeout  out  1  response produced by the watchdog (tied 0 without the feature)
- awaddr / awvalid / awready  out / out / in  ADDR_WIDTH / 1 / 1  AXI write-address channel
- wdata / wvalid / wready  out / out / in  DATA_WIDTH / 1 / 1  AXI write-data channel
- bresp / bvalid / bready  in / in / out  2 / 1 / 1  AXI write-response channel
- araddr / arvalid / arready  out / out / in  ADDR_WIDTH / 1 / 1  AXI read-address channel
- rdata / rresp / rvalid / rready  in / in / in / out  DATA_WIDTH / 2 / 1 / 1  AXI read-data channel

Behaviour:
- Reset values: state IDLE; all valid/ready outputs 0 except cmd_ready = 1; addr/data/rsp_* = 0.
- All outputs are registered; no combinational path from any input to any output.
- Strobes: AXI4-Lite with no wstrb and no prot; all bytes are written.
- IDLE: cmd_ready = 1. On cmd_valid: latch addr/wdata, drop cmd_ready; go to WR (write) or RD_ADDR (read).
- WR: awvalid = wvalid = 1 from the first cycle after accept.
  - aw_done is set on awvalid && awready; awvalid drops the next cycle.
  - w_done is set likewise on wvalid && wready.
  - Handshakes may occur in either order or in the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: bready = 1. On bvalid, latch bresp and go to RSP.
- RD_ADDR: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, latch rdata/rresp and go to RSP.
- RSP: rsp_valid = 1 with stable payload until rsp_ready; then go to IDLE, cmd_ready = 1 the next cycle.
- Valids, once asserted, are never dropped before their handshake. Address/data are stable while valid.
- Bready and rready are asserted only in their respective states.
- Minimum latency with a zero-wait slave:
  - write: accept at cycle 0, AW/W at cycle 1, B at cycle 2, rsp_valid at cycle 3;
  - read: accept at 0, AR at 1, R at 2, rsp_valid at 3.
- Non-zero rsp_resp (SLVERR 2'b10, DECERR 2'b11) is passed through unchanged; it is not an error for the block.
- A bvalid or rvalid outside the expected state is ignored; the matching ready is 0 there.
- Reset mid-transaction: all valids are forced to 0 immediately (asynchronous). The slave must be reset together with this block.

Optional Feature:
- Macro: AXIL_CFG_MASTER_TIMEOUT_EN.
- With it:
  - a counter runs in the WR, WR_RESP, RD_ADDR and RD_DATA states and clears on every state change;
  - on reaching TIMEOUT_CYCLES, all AXI valids/readies drop and the block goes to RSP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
- Without it: no counter; rsp_timeout is tied to 0; the block waits on the slave indefinitely.

Decomposition:
- Package axil_cfg_master_pkg: state enum (IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP) and response constants (RESP_OKAY 2'b00, RESP_SLVERR 2'b10, RESP_DECERR 2'b11).
- Width parameters come from global_buffer_param.
- Optional sub-module axil_cfg_watchdog: counter plus expiry flag, instantiated only under the macro.

Test Plan:
- Zero-wait write, addr 0x0010, data 0xDEADBEEF -> AW/W asserted at cycle 1, bready at cycle 2, rsp_valid at cycle 3 with rsp_resp = 0, rsp_rdata = 0.
- Read of addr 0x0010 after the write -> araddr = 0x0010, rsp_rdata = 0xDEADBEEF at cycle 3.
- Skewed write, awready 3 cycles late and wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with constant awaddr, a single B accepted.
- Slave returns rresp = 2'b10, with rsp_ready held low 5 cycles -> rsp_valid and payload stable 5 cycles, cmd_ready = 0 throughout, cmd_ready = 1 the cycle after the consume.
- Reset asserted while arvalid = 1 -> arvalid = 0 and cmd_ready = 1 with no clock edge; a new read completes normally afterwards.
- With AXIL_CFG_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 16, arready held 0 -> arvalid drops after 16 cycles, rsp_timeout = 1, rsp_resp = 2'b10.
